// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared defaults and per-channel state for the tick generator
package tick_gen_pkg;
    localparam int NCH_DEF = 2;
    localparam int DIV_W_DEF = 10;
    localparam int DIV_W_MAX = 32;
    typedef struct packed {
        logic [DIV_W_MAX-1:0] cnt;
        logic [DIV_W_MAX-1:0] act;
        logic [DIV_W_MAX-1:0] shd;
        logic                 pend;
    } chan_t;
    function automatic logic [DIV_W_MAX-1:0] ones(int w);
        return (w >= DIV_W_MAX) ? {DIV_W_MAX{1'b1}} : (32'd1 << w) - 32'd1;
    endfunction
endpackage

// File: rtl/tick_gen_chan.sv
// tick_gen_chan: one down-counting tick channel with shadowed divisor
module tick_gen_chan import tick_gen_pkg::*; #(
    parameter int DIV_W = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_INIT = DIV_W'(ones(DIV_W))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             sync,
    input  logic             we,
    input  logic [DIV_W-1:0] val,
    output logic             zero,
    output logic             tick,
    output logic             pend
);
    chan_t s, n;
    logic term;
    logic [DIV_W_MAX-1:0] ld;
    assign zero = s.cnt == '0;
    assign pend = s.pend;
    always_comb begin
        term = step & zero & ~sync;
        ld = s.pend ? s.shd : s.act;
        n.cnt = (sync | term) ? ld : step ? s.cnt - 32'd1 : s.cnt;
        n.act = (sync | term) ? ld : s.act;
        n.shd = we ? DIV_W_MAX'(val) : s.shd;
        n.pend = we | (~(sync | term) & s.pend);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '{cnt: DIV_W_MAX'(DIV_INIT), act: DIV_W_MAX'(DIV_INIT), shd: DIV_W_MAX'(DIV_INIT), pend: 1'b0};
            tick <= 1'b0;
        end else begin
            s <= n;
            tick <= term;
        end
    end
endmodule

// File: rtl/tick_gen.sv
// tick_gen: NCH programmable tick channels with optional cascading
module tick_gen import tick_gen_pkg::*; #(
    parameter int NCH = NCH_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_INIT = DIV_W'(ones(DIV_W)),
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   casc,
    input  logic             sync,
    input  logic             div_we,
    input  logic [CW-1:0]    div_ch,
    input  logic [DIV_W-1:0] div_val,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pend
);
    logic [NCH-1:0] step, zero;
    logic c;
    always_comb begin
        c = 1'b1;
        step = '0;
        for (int k = 0; k < NCH; k++) begin
            step[k] = en[k] & (~casc[k] | c);
            c = step[k] & zero[k];
        end
    end
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_gen_chan #(.DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) u_chan (
            .clk  (clk),
            .rst  (rst),
            .step (step[i]),
            .sync (sync),
            .we   (div_we && div_ch == CW'(i)),
            .val  (div_val),
            .zero (zero[i]),
            .tick (tick[i]),
            .pend (pend[i])
        );
    end
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed and random checks of tick_gen against a reference model
module tb_tick_gen;
    localparam int NCH = 3;
    localparam int DW = 10;
    localparam int CW = 2;
    localparam int INIT = 1023;
    logic clk = 0, rst = 1, sync = 0, div_we = 0;
    logic [NCH-1:0] en = '0, casc = '0;
    logic [CW-1:0] div_ch = '0;
    logic [DW-1:0] div_val = '0;
    logic [NCH-1:0] tick, pend;
    int checks = 0, errs = 0;
    int unsigned m_rem[NCH], m_act[NCH], m_shd[NCH];
    logic [NCH-1:0] m_pend, m_tick;

    tick_gen #(.NCH(NCH), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .casc(casc), .sync(sync), .div_we(div_we),
        .div_ch(div_ch), .div_val(div_val), .tick(tick), .pend(pend)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each channel counts remaining steps to its terminal; terminal reloads the period.
    task automatic model();
        bit prev_fire = 1;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_rem[i] = INIT; m_act[i] = INIT; m_shd[i] = INIT;
            end
            m_pend = '0; m_tick = '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                bit stp, fire;
                stp = en[i] && (i == 0 || !casc[i] || prev_fire);
                fire = stp && m_rem[i] == 0;
                m_tick[i] = fire && !sync;
                if (sync || fire) begin
                    if (m_pend[i]) m_act[i] = m_shd[i];
                    m_rem[i] = m_act[i];
                    m_pend[i] = 1'b0;
                end else if (stp) m_rem[i] = m_rem[i] - 1;
                if (div_we && int'(div_ch) == i) begin
                    m_shd[i] = div_val;
                    m_pend[i] = 1'b1;
                end
                prev_fire = fire;
            end
        end
    endtask

    task automatic cyc();
        model();
        @(posedge clk);
        #1;
        chk("tick", tick, m_tick);
        chk("pend", pend, m_pend);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_tick(int ch, int max, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick[ch] && n < max);
    endtask

    task automatic wr(int ch, int val);
        div_ch = CW'(ch);
        div_val = DW'(val);
        div_we = 1;
        cyc();
        div_we = 0;
    endtask

    task automatic pulse_sync();
        sync = 1;
        cyc();
        sync = 0;
    endtask

    initial begin
        int n, t0, t1;
        run(2);
        chk("reset_tick", tick, 0);
        chk("reset_pend", pend, 0);
        rst = 0;
        en = 3'b001;
        wait_tick(0, 1100, n);
        chk("first_period", n, 1024);
        wait_tick(0, 1100, n);
        chk("second_period", n, 1024);

        en = '0;
        wr(0, 31);
        wr(1, 31);
        pulse_sync();
        casc = 3'b010;
        en = 3'b011;
        wait_tick(1, 1100, n);
        chk("casc_period", n, 1024);
        chk("casc_coincident", tick[0], 1);
        wait_tick(1, 1100, n);
        chk("casc_period2", n, 1024);

        casc = '0;
        en = '0;
        wr(0, 9);
        pulse_sync();
        en = 3'b001;
        wait_tick(0, 30, n);
        chk("d9_period", n, 10);
        run(3);
        wr(0, 4);
        chk("pend_after_write", pend[0], 1);
        wait_tick(0, 30, n);
        chk("old_period_rest", n, 6);
        chk("pend_applied", pend[0], 0);
        wait_tick(0, 30, n);
        chk("d4_period", n, 5);

        wr(0, 2);
        run(3);
        wr(0, 6);
        chk("term_write_tick", tick[0], 1);
        chk("term_write_pend", pend[0], 1);
        wait_tick(0, 30, n);
        chk("d2_period", n, 3);
        chk("d6_applied", pend[0], 0);
        wait_tick(0, 30, n);
        chk("d6_period", n, 7);

        en = '0;
        wr(0, 7);
        wr(1, 3);
        pulse_sync();
        en = 3'b011;
        run(2);
        pulse_sync();
        chk("sync_drop", tick, 0);
        t0 = 0;
        t1 = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (tick[0] && t0 == 0) t0 = i;
            if (tick[1] && t1 == 0) t1 = i;
        end
        chk("sync_restart0", t0, 8);
        chk("sync_restart1", t1, 4);
        en = '0;
        run(5);
        chk("frozen", tick, 0);
        en = 3'b001;
        wait_tick(0, 30, n);
        chk("freeze_resume", n, 8);

        en = '0;
        wr(0, 0);
        pulse_sync();
        en = 3'b001; cyc(); chk("d0_en1", tick[0], 1);
        en = 3'b000; cyc(); chk("d0_en0", tick[0], 0);
        en = 3'b001; cyc(); chk("d0_en1b", tick[0], 1);
        en = 3'b001; cyc(); chk("d0_en1c", tick[0], 1);
        wr(3, 5);
        chk("bad_ch_pend", pend, 0);
        cyc();
        chk("bad_ch_tick", tick[0], 1);

        for (int i = 0; i < 3000; i++) begin
            en = NCH'($urandom);
            casc = NCH'($urandom);
            sync = $urandom_range(0, 15) == 0;
            div_we = $urandom_range(0, 3) == 0;
            div_ch = CW'($urandom_range(0, 3));
            div_val = ($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'($urandom_range(0, 12));
            rst = $urandom_range(0, 199) == 0;
            cyc();
        end
        rst = 0;
        sync = 0;
        div_we = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter NCH, default 2: number of independent tick channels (1..16).
REQ-002 Parameter DIV_W, default 10: divisor and counter width in bits (2..32).
REQ-003 Parameter DIV_INIT, default all-ones of DIV_W: divisor loaded into every channel at reset.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  NCH  per-channel count enable.
REQ-007 casc  in  NCH  per-channel cascade mode; 1 = channel steps only on the terminal count of channel i-1; bit 0 ignored.
REQ-008 sync  in  1  one-cycle restart of all channels.
REQ-009 div_we  in  1  divisor write strobe.
REQ-010 div_ch  in  clog2(NCH), min 1  target channel for div_we.
REQ-011 div_val  in  DIV_W  new divisor D; period = D+1 steps.
REQ-012 tick  out  NCH  registered one-cycle strobe per channel terminal count.
REQ-013 pend  out  NCH  registered; 1 = shadow divisor written but not yet applied.

Function
REQ-014 Each channel holds cnt, act (active divisor) and shd (shadow divisor), all DIV_W bits wide.
REQ-015 step[0] = en[0]; for i>0, step[i] = en[i] AND (casc[i] ? (step[i-1] AND cnt[i-1]==0) : 1); evaluated combinationally in the same cycle.
REQ-016 Step with cnt!=0: cnt <= cnt-1, tick[i] <= 0.
REQ-017 Step with cnt==0 (terminal): tick[i] <= 1; if pend[i], then act <= shd, cnt <= shd, pend <= 0; otherwise cnt <= act.
REQ-018 No step: cnt, act and pend hold; tick[i] <= 0.
REQ-019 D=0 gives tick on every stepped cycle; D=2^DIV_W-1 is a legal period of 2^DIV_W steps; cnt never wraps below 0.
REQ-020 div_we: shd[div_ch] <= div_val and pend[div_ch] <= 1; div_ch >= NCH is ignored with no state change.
REQ-021 A write in the same cycle as that channel's terminal count: the terminal transfer uses the prior shd if pend was set; the new value lands in shd and pend ends at 1.
REQ-022 Back-to-back writes before a terminal count: the last write wins.
REQ-023 sync=1: every channel sets cnt <= (pend ? shd : act), act <= the same value, pend <= 0, tick <= 0; sync overrides en, casc and terminal count.
REQ-024 A div_we coinciding with sync is applied after the sync effect: shd is written and pend ends at 1.
REQ-025 Latency: tick asserts on the cycle after the terminal step, one-cycle registered delay; no combinational path from inputs to outputs.

Reset
REQ-026 rst=1: cnt=act=shd=DIV_INIT, pend=0, tick=0 for all channels; rst overrides sync and div_we.
REQ-027 Reset asserted mid-period discards any pending divisor.
REQ-028 First tick after reset release with en=1, casc=0 appears DIV_INIT+1 cycles after the first enabled cycle.

Structure
REQ-029 Package tick_gen_pkg holds the defaults for NCH, DIV_W and DIV_INIT and the per-channel state struct (cnt, act, shd, pend).
REQ-030 Sub-module tick_gen_chan implements one channel (REQ-016..018, 020..024); tick_gen instantiates NCH of them and builds the step chain.

Verification
REQ-031 Reset, DIV_W=10, en[0]=1 held: tick[0] pulses exactly every 1024 cycles, first pulse 1024 cycles after the first enabled cycle.
REQ-032 Cascade, ch0 D=31, ch1 D=31, casc[1]=1: tick[1] once per 32 tick[0] pulses (every 1024 cycles), coincident with a tick[0] pulse.
REQ-033 Write D=4 to ch0 mid-period with old D=9: pend[0]=1 until the next terminal; the remaining old period completes, then ticks every 5 cycles.
REQ-034 Write coincident with terminal count: the old pending value is applied, pend stays 1, and the new value is applied at the following terminal.
REQ-035 sync pulse mid-count on 2 channels, D=7 and D=3: both ticks drop and restart; next ticks arrive 8 and 4 cycles later; en=0 freezes a count with no tick.
REQ-036 D=0 with en toggling 1,0,1,1: tick follows en delayed one cycle; div_ch=NCH write causes no change.
